pipelined_adder: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor. Successor to the 3-bit adders:
//   - operand width and pipeline depth are parameters
//   - adds subtract mode
//   - adds valid/ready handshakes with backpressure on both sides

---
 rtl/adder_pkg.sv | 9 +
 rtl/adder_chunk.sv | 26 ++
 rtl/pipelined_adder.sv | 140 ++++++++++++++
 tb/tb_pipelined_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder/subtractor.
package adder_pkg;

   // Bits handled by each pipeline stage.
   function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder built from full-adder cells.
module adder_chunk #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         msb_cin
);

   logic [W:0] w_c;

   assign w_c[0] = cin;

   // One full-adder cell per bit.
   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s[i]       = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]   = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign cout    = w_c[W];
   assign msb_cin = w_c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Stage k adds chunk k; upper operand chunks ride along, finished low sum
// chunks are carried forward. Optional signed-overflow output out_ovf is
// enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 12,
   parameter int unsigned STAGES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);
   localparam int unsigned LAST  = STAGES - 1;

   // Stage payload: operands stay full width, stage k consumes chunk k.
   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [WIDTH-1:0] sum_lo;
      logic [WIDTH-1:0] a_hi;
      logic [WIDTH-1:0] b_hi;
      logic             sub;
   } stage_t;

   if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), STAGES >= 1",
             WIDTH, STAGES);
   end

   stage_t                        r_pipe [STAGES];
   stage_t                        w_src  [STAGES];
   stage_t                        w_nxt  [STAGES];
   logic [STAGES-1:0]             w_load;
   logic [STAGES-1:0][CHUNK-1:0]  w_ca;
   logic [STAGES-1:0][CHUNK-1:0]  w_cb;
   logic [STAGES-1:0][CHUNK-1:0]  w_cs;
   logic [STAGES-1:0]             w_cc;
   logic [STAGES-1:0]             w_cco;
   logic [STAGES-1:0]             w_cmsb;

   // Route each stage's source (input beat or previous register) to its chunk adder.
   always_comb begin
      w_src[0].valid  = in_valid;
      w_src[0].carry  = in_cin ^ in_sub;
      w_src[0].sum_lo = '0;
      w_src[0].a_hi   = in_a;
      w_src[0].b_hi   = in_b;
      w_src[0].sub    = in_sub;
      for (int k = 1; k < int'(STAGES); k++) begin
         w_src[k] = r_pipe[k-1];
      end
      for (int k = 0; k < int'(STAGES); k++) begin
         w_ca[k] = w_src[k].a_hi[k*CHUNK +: CHUNK];
         w_cb[k] = w_src[k].b_hi[k*CHUNK +: CHUNK] ^ {CHUNK{w_src[k].sub}};
         w_cc[k] = w_src[k].carry;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_chunk #(.W(CHUNK)) u_chunk (
         .a       (w_ca[k]),
         .b       (w_cb[k]),
         .cin     (w_cc[k]),
         .s       (w_cs[k]),
         .cout    (w_cco[k]),
         .msb_cin (w_cmsb[k])
      );
   end

   // Merge each stage's chunk result into its payload.
   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         w_nxt[k]                            = w_src[k];
         w_nxt[k].sum_lo[k*CHUNK +: CHUNK]   = w_cs[k];
         w_nxt[k].carry                      = w_cco[k];
      end
   end

   // Backpressure chain: a stage loads when empty or when its content moves on.
   always_comb begin
      w_load       = '0;
      w_load[LAST] = !r_pipe[LAST].valid || out_ready;
      for (int k = int'(STAGES) - 2; k >= 0; k--) begin
         w_load[k] = !r_pipe[k].valid || w_load[k+1];
      end
   end

   // Stage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            r_pipe[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (w_load[k]) begin
               r_pipe[k] <= w_nxt[k];
            end
         end
      end
   end

   assign in_ready  = w_load[0];
   assign out_valid = r_pipe[LAST].valid;
   assign out_sum   = r_pipe[LAST].sum_lo;
   assign out_cout  = r_pipe[LAST].carry;

`ifdef PIPELINED_ADDER_OVF_EN
   logic r_ovf;

   // Signed overflow: carry into MSB differs from carry out of MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_load[LAST]) begin
         r_ovf <= w_cmsb[LAST] ^ w_cco[LAST];
      end
   end

   assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=12).
module tb_pipelined_adder;

   parameter int unsigned STAGES = 3;
   localparam int unsigned WIDTH = 12;
   localparam int NB   = int'(STAGES) + 3;
   localparam int HOLD = int'(STAGES) + 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
`ifdef PIPELINED_ADDER_OVF_EN
   logic             out_ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference result {cout, sum}.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
      if (sub) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(!cin);
      else     return {1'b0, a} + {1'b0, b}  + (WIDTH+1)'(cin);
   endfunction

   // One beat through an idle pipe: latency, sum, carry and (optionally) overflow.
   task automatic run_one(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic cin, input logic sub,
                          input logic [11:0] es, input logic ec, input logic eo);
      int lat;
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
      #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(STAGES));
      check({tag, ".sum"}, 32'(out_sum), 32'(es));
      check({tag, ".cout"}, 32'(out_cout), 32'(ec));
`ifdef PIPELINED_ADDER_OVF_EN
      check({tag, ".ovf"}, 32'(out_ovf), 32'(eo));
`else
      if (eo === 1'bz) $display("unused");
`endif
      @(negedge clk);
   endtask

   logic [11:0] sa [NB];
   logic [11:0] sb [NB];
   logic        sc [NB];
   logic        ss [NB];
   logic [12:0] se [NB];

   initial begin
      int sent, recv, first_dlv, last_dlv, fill_seen, bad;
      logic [12:0] r;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.out_sum", 32'(out_sum), 32'd0);
      check("reset.out_cout", 32'(out_cout), 32'd0);

      // Directed add/sub vectors.
      run_one("add_2_2",    12'h002, 12'h002, 1'b0, 1'b0, 12'h004, 1'b0, 1'b0);
      run_one("ripple_00f", 12'h00F, 12'h001, 1'b0, 1'b0, 12'h010, 1'b0, 1'b0);
      run_one("ripple_fff", 12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
      run_one("ripple_cin", 12'h0FF, 12'hF01, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0);
      run_one("sub_6_5",    12'h006, 12'h005, 1'b0, 1'b1, 12'h001, 1'b1, 1'b0);
      run_one("sub_5_6",    12'h005, 12'h006, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0);
      run_one("sub_5_5_b",  12'h005, 12'h005, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
      run_one("ovf_add",    12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
      run_one("ovf_sub",    12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1);
      run_one("add_3_6",    12'h003, 12'h006, 1'b0, 1'b0, 12'h009, 1'b0, 1'b0);

      // Backpressure stream: out_ready low for HOLD cycles, then released.
      for (int i = 0; i < NB; i++) begin
         sa[i] = 12'(37 * i + 5);
         sb[i] = 12'(12'h0F0 + i);
         sc[i] = (i % 3) == 0;
         ss[i] = (i % 2) == 1;
         se[i] = model(sa[i], sb[i], sc[i], ss[i]);
      end
      sent = 0; recv = 0; first_dlv = -1; last_dlv = -1; fill_seen = 0;
      for (int c = 0; c < HOLD + NB + 20 && recv < NB; c++) begin
         @(negedge clk);
         out_ready = (c >= HOLD);
         in_valid  = (sent < NB);
         if (sent < NB) begin
            in_a = sa[sent]; in_b = sb[sent]; in_cin = sc[sent]; in_sub = ss[sent];
         end
         #1;
         if (!in_ready && fill_seen == 0) begin
            fill_seen = 1;
            check("bp.accepts_at_full", 32'(sent), 32'(STAGES));
         end
         if (out_valid && !out_ready) begin
            check("bp.stall_sum", 32'(out_sum), 32'(se[recv][11:0]));
         end
         if (out_valid && out_ready) begin
            check("bp.order_sum", 32'(out_sum), 32'(se[recv][11:0]));
            check("bp.order_cout", 32'(out_cout), 32'(se[recv][12]));
            if (first_dlv < 0) first_dlv = c;
            last_dlv = c;
            recv++;
         end
         if (in_valid && in_ready) sent++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("bp.all_received", 32'(recv), 32'(NB));
      check("bp.full_seen", 32'(fill_seen), 32'd1);
      check("bp.first_delivery", 32'(first_dlv), 32'(HOLD));
      check("bp.last_delivery", 32'(last_dlv), 32'(HOLD + NB - 1));
      #1 check("bp.drained", 32'(out_valid), 32'd0);

      // Reset mid-stream discards in-flight beats.
      out_ready = 1'b0;
      for (int i = 0; i < int'(STAGES) + 1; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = 12'(i + 1); in_b = 12'h001; in_cin = 1'b0; in_sub = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("rst_mid.pre_valid", 32'(out_valid), 32'd1);
      #1 rst = 1'b1;
      #1 check("rst_mid.valid_drop", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 2 * int'(STAGES) + 2; i++) begin
         @(negedge clk);
         #1 if (out_valid) bad++;
      end
      check("rst_mid.no_stale", 32'(bad), 32'd0);

      r = model(12'h123, 12'h456, 1'b1, 1'b0);
      run_one("post_rst", 12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, r[12], 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
